// File: rtl/heartbeat_monitor.sv
// Heartbeat monitor: measures the cycle distance between toggles of an
// asynchronous heartbeat and checks it against a tolerance window.
module heartbeat_monitor #(
  parameter int unsigned CLOCK_FREQ_MHZ = 250,
  parameter int unsigned INTERVAL_MSEC  = 500,
  parameter int unsigned TOLERANCE_PCT  = 10,
  // 64-bit arithmetic so EXPECT*TOLERANCE_PCT cannot overflow
  localparam longint unsigned EXPECT      = 64'(CLOCK_FREQ_MHZ) * 64'(INTERVAL_MSEC) * 64'd1000,
  localparam longint unsigned TOL         = EXPECT * 64'(TOLERANCE_PCT) / 64'd100,
  localparam longint unsigned MIN_CYC     = EXPECT - TOL,
  localparam longint unsigned TIMEOUT_CYC = EXPECT + TOL,
  localparam int unsigned     W           = $clog2(TIMEOUT_CYC + 64'd1)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         HB_IN,
  input  logic         CLEAR_ERR,
  output logic [W-1:0] PERIOD_OUT,
  output logic         PERIOD_VALID,
  output logic         ALIVE,
  output logic         ERR_FAST,
  output logic         ERR_TIMEOUT
);

  localparam logic [W-1:0] MinW     = W'(MIN_CYC);
  localparam logic [W-1:0] TimeoutW = W'(TIMEOUT_CYC);

  typedef enum logic [0:0] {StWait, StMeasure} state_e;

  logic         s1_q, s2_q, s3_q;
  logic         hb_edge;
  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         alive_q, alive_d;
  logic         fast_q, fast_d;
  logic         tout_q, tout_d;
  logic         fast_set, tout_set;

  // Free-running synchronizer; s3 only serves the edge detector
  always_ff @(posedge CLK) begin
    s1_q <= HB_IN;
    s2_q <= s1_q;
    s3_q <= s2_q;
  end

  assign hb_edge = (s2_q ^ s3_q) & ~RESET;

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StWait;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      alive_q  <= 1'b0;
      fast_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      alive_q  <= alive_d;
      fast_q   <= fast_d;
      tout_q   <= tout_d;
    end
  end

  // Next-state: interval measurement, window check and sticky error flags
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    alive_d  = alive_q;
    fast_set = 1'b0;
    tout_set = 1'b0;
    unique case (state_q)
      StWait: begin
        cnt_d = '0;
        // First edge only arms; there is no previous edge to measure from
        if (hb_edge) begin
          state_d = StMeasure;
          cnt_d   = W'(1);
        end
      end
      StMeasure: begin
        // Edge takes priority over timeout when both land on the same cycle
        if (hb_edge) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          cnt_d    = W'(1);
          if (cnt_q < MinW) begin
            fast_set = 1'b1;
            alive_d  = 1'b0;
          end else begin
            alive_d  = 1'b1;
          end
        end else if (cnt_q == TimeoutW) begin
          tout_set = 1'b1;
          alive_d  = 1'b0;
          state_d  = StWait;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      default: state_d = StWait;
    endcase
    // A set condition beats a simultaneous clear
    fast_d = fast_set | (fast_q & ~CLEAR_ERR);
    tout_d = tout_set | (tout_q & ~CLEAR_ERR);
  end

  assign PERIOD_OUT   = period_q;
  assign PERIOD_VALID = valid_q;
  assign ALIVE        = alive_q;
  assign ERR_FAST     = fast_q;
  assign ERR_TIMEOUT  = tout_q;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Bench for heartbeat_monitor: timestamp-based reference model checked every
// cycle, plus directed literal expectations along the scenario.
module tb_heartbeat_monitor;

  localparam int MinCyc  = 900;
  localparam int Timeout = 1100;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        HB_IN;
  logic        CLEAR_ERR;
  logic [10:0] PERIOD_OUT;
  logic        PERIOD_VALID;
  logic        ALIVE;
  logic        ERR_FAST;
  logic        ERR_TIMEOUT;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: edge timestamps rather than a counter
  bit hb_q[$];
  int cyc    = 0;
  int m_last = 0;
  bit armed  = 0;
  bit m_known = 0;
  int e_per  = 0;
  bit e_val  = 0;
  bit e_alive = 0;
  bit e_fast = 0;
  bit e_to   = 0;

  int p;
  int per;
  int p_tot;

  heartbeat_monitor #(
    .CLOCK_FREQ_MHZ(1),
    .INTERVAL_MSEC (1),
    .TOLERANCE_PCT (10)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .HB_IN       (HB_IN),
    .CLEAR_ERR   (CLEAR_ERR),
    .PERIOD_OUT  (PERIOD_OUT),
    .PERIOD_VALID(PERIOD_VALID),
    .ALIVE       (ALIVE),
    .ERR_FAST    (ERR_FAST),
    .ERR_TIMEOUT (ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // A level sampled at posedge c becomes a detected edge at posedge c+2
  task automatic model_step();
    bit ed;
    bit fset;
    bit tset;
    int n;
    hb_q.push_back(HB_IN);
    cyc++;
    ed = (hb_q.size() >= 4) && (hb_q[$-2] != hb_q[$-3]);
    if (RESET) begin
      m_known = 1; armed = 0;
      e_per = 0; e_val = 0; e_alive = 0; e_fast = 0; e_to = 0;
    end else begin
      fset = 0; tset = 0; e_val = 0;
      if (ed) begin
        if (armed) begin
          n = cyc - m_last;
          e_per = n;
          e_val = 1;
          if (n < MinCyc) begin fset = 1; e_alive = 0; end
          else e_alive = 1;
        end
        armed = 1;
        m_last = cyc;
      end else if (armed && (cyc - m_last >= Timeout)) begin
        tset = 1; e_alive = 0; armed = 0;
      end
      e_fast = fset || (e_fast && !CLEAR_ERR);
      e_to   = tset || (e_to && !CLEAR_ERR);
    end
  endtask

  task automatic compare();
    logic [10:0] ep;
    if (!m_known) return;
    ep = 11'(e_per);
    n_chk++;
    if (PERIOD_OUT !== ep || PERIOD_VALID !== e_val || ALIVE !== e_alive ||
        ERR_FAST !== e_fast || ERR_TIMEOUT !== e_to) begin
      n_err++;
      $display("FAIL model cycle %0d: got per=%0d v=%b a=%b f=%b t=%b, need per=%0d v=%b a=%b f=%b t=%b",
               cyc, PERIOD_OUT, PERIOD_VALID, ALIVE, ERR_FAST, ERR_TIMEOUT,
               ep, e_val, e_alive, e_fast, e_to);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    compare();
  endtask

  task automatic dchk(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, need %0d", name, got, exp);
    end
  endtask

  task automatic run(input int n, output int pulses, output int last_per);
    pulses = 0;
    last_per = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (PERIOD_VALID === 1'b1) begin
        pulses++;
        last_per = int'(PERIOD_OUT);
      end
    end
  endtask

  // Toggle, then wait gap cycles; a pulse inside reports the previous gap
  task automatic hb_step(input int gap, output int pulses, output int last_per);
    HB_IN = ~HB_IN;
    run(gap, pulses, last_per);
  endtask

  initial begin
    RESET = 1'b1; HB_IN = 1'b1; CLEAR_ERR = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    dchk("rst_period", int'(PERIOD_OUT), 0);
    dchk("rst_valid", int'(PERIOD_VALID), 0);
    dchk("rst_alive", int'(ALIVE), 0);
    dchk("rst_fast", int'(ERR_FAST), 0);
    dchk("rst_timeout", int'(ERR_TIMEOUT), 0);
    RESET = 1'b0;
    run(10, p, per);
    dchk("no_valid_after_reset", p, 0);

    // Nominal
    hb_step(1000, p, per);
    dchk("arm_no_valid", p, 0);
    hb_step(1000, p, per);
    dchk("nominal_pulses", p, 1);
    dchk("nominal_period", per, 1000);
    dchk("nominal_alive", int'(ALIVE), 1);
    dchk("nominal_fast", int'(ERR_FAST), 0);
    dchk("nominal_timeout", int'(ERR_TIMEOUT), 0);

    // Lower bound
    hb_step(899, p, per);
    dchk("pre_fast_period", per, 1000);
    hb_step(900, p, per);
    dchk("fast_period", per, 899);
    dchk("fast_flag", int'(ERR_FAST), 1);
    dchk("fast_alive", int'(ALIVE), 0);
    hb_step(1000, p, per);
    dchk("min_period", per, 900);
    dchk("min_alive", int'(ALIVE), 1);
    dchk("min_fast_sticky", int'(ERR_FAST), 1);

    // Timeout: last edge was at tick 3 of the previous step
    run(102, p, per);
    dchk("pre_timeout_flag", int'(ERR_TIMEOUT), 0);
    dchk("pre_timeout_alive", int'(ALIVE), 1);
    run(1, p, per);
    dchk("timeout_flag", int'(ERR_TIMEOUT), 1);
    dchk("timeout_alive", int'(ALIVE), 0);
    dchk("timeout_period_kept", int'(PERIOD_OUT), 900);
    CLEAR_ERR = 1'b1;
    tick();
    CLEAR_ERR = 1'b0;
    dchk("clear_fast", int'(ERR_FAST), 0);
    dchk("clear_timeout", int'(ERR_TIMEOUT), 0);
    hb_step(1000, p, per);
    dchk("rearm_no_valid", p, 0);
    hb_step(1100, p, per);
    dchk("rearm_period", per, 1000);
    dchk("rearm_alive", int'(ALIVE), 1);
    hb_step(899, p, per);
    dchk("max_period", per, 1100);
    dchk("max_alive", int'(ALIVE), 1);
    dchk("max_no_timeout", int'(ERR_TIMEOUT), 0);

    // Clear priority: CLEAR_ERR on the same edge as an 899-cycle interval
    HB_IN = ~HB_IN;
    tick();
    tick();
    CLEAR_ERR = 1'b1;
    tick();
    CLEAR_ERR = 1'b0;
    dchk("clrpri_period", int'(PERIOD_OUT), 899);
    dchk("clrpri_fast", int'(ERR_FAST), 1);
    dchk("clrpri_alive", int'(ALIVE), 0);
    CLEAR_ERR = 1'b1;
    tick();
    CLEAR_ERR = 1'b0;
    dchk("clr_late_fast", int'(ERR_FAST), 0);
    dchk("clr_late_alive", int'(ALIVE), 0);
    run(996, p, per);

    // Reset mid-measurement at cnt = 500
    hb_step(502, p, per);
    dchk("pre_rst_alive", int'(ALIVE), 1);
    RESET = 1'b1;
    run(3, p, per);
    RESET = 1'b0;
    dchk("midrst_period", int'(PERIOD_OUT), 0);
    dchk("midrst_alive", int'(ALIVE), 0);
    dchk("midrst_fast", int'(ERR_FAST), 0);
    dchk("midrst_timeout", int'(ERR_TIMEOUT), 0);
    hb_step(1000, p, per);
    p_tot = p;
    hb_step(1000, p, per);
    p_tot += p;
    dchk("midrst_single_pulse", p_tot, 1);
    dchk("midrst_period_after", per, 1000);
    run(20, p, per);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/heartbeat_monitor.md
# heartbeat_monitor

Receive-side counterpart to the on-board LED blinker. Takes a slow toggling heartbeat (HB_IN, 50 % duty, one toggle per INTERVAL_MSEC) that may come from another clock domain. Measures the cycle count between toggles and checks it against a tolerance window. Reports the last interval, an ALIVE status and sticky too-fast / timeout errors. Sits next to the board status logic, one instance per monitored heartbeat.

## Interface
- CLOCK_FREQ_MHZ, 250, CLK frequency in MHz
- INTERVAL_MSEC, 500, expected time between HB_IN toggles
- TOLERANCE_PCT, 10, allowed deviation in percent (integer, 0..99)
- Derived (localparam):
  - EXPECT = CLOCK_FREQ_MHZ*INTERVAL_MSEC*1000
  - TOL = EXPECT*TOLERANCE_PCT/100
  - MIN_CYC = EXPECT-TOL
  - TIMEOUT_CYC = EXPECT+TOL
  - W = ceil(log2(TIMEOUT_CYC+1))
  - TIMEOUT_CYC must fit in a 32-bit integer.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- HB_IN  in  1  asynchronous heartbeat; each level must be held ≥2 CLK cycles
- CLEAR_ERR  in  1  clears sticky error flags
- PERIOD_OUT  out  W  last measured interval in CLK cycles
- PERIOD_VALID  out  1  one-cycle pulse when PERIOD_OUT updates
- ALIVE  out  1  last interval in window and no timeout since
- ERR_FAST  out  1  sticky, an interval < MIN_CYC was seen
- ERR_TIMEOUT  out  1  sticky, no toggle within TIMEOUT_CYC

## Operation
- Synchronizer and edge detect:
  - s1 <= HB_IN, s2 <= s1, s3 <= s2; these flops are free-running and not reset.
  - edge = s2 ^ s3; both polarities count.
  - edge is ignored while RESET = 1.
  - RESET must be held ≥3 cycles so the chain settles without a spurious edge.
- Counter cnt (W bits):
  - Loads 1 on the cycle edge is seen, then increments each cycle.
  - At the next edge, cnt equals the cycle distance between the two edge detections.
- States: WAIT, MEASURE.
  - WAIT: cnt held at 0. On edge: go to MEASURE, cnt <= 1, no PERIOD_VALID.
  - MEASURE, edge with interval N = cnt:
    - PERIOD_OUT <= N, PERIOD_VALID <= 1, cnt <= 1, stay in MEASURE.
    - N < MIN_CYC: ERR_FAST <= 1, ALIVE <= 0.
    - MIN_CYC ≤ N ≤ TIMEOUT_CYC: ALIVE <= 1.
  - MEASURE, no edge and cnt == TIMEOUT_CYC:
    - ERR_TIMEOUT <= 1, ALIVE <= 0, go to WAIT, cnt <= 0.
    - PERIOD_OUT is unchanged.
  - Edge in the same cycle as cnt == TIMEOUT_CYC: the edge wins; the interval is good and no timeout is flagged.
  - cnt never wraps; timeout occurs first.
- Error flags:
  - CLEAR_ERR clears ERR_FAST and ERR_TIMEOUT.
  - A set condition in the same cycle as CLEAR_ERR wins; the flag stays 1.
  - CLEAR_ERR does not affect ALIVE, PERIOD_OUT or the state.
- Reset: state WAIT, cnt 0, and all outputs 0 (PERIOD_OUT 0, PERIOD_VALID 0, ALIVE 0, ERR_FAST 0, ERR_TIMEOUT 0).
  - Reset mid-measurement discards the partial interval.
  - The first edge after reset only arms the block.

## Timing
- HB_IN change sampled at posedge k → s1 at k, s2 at k+1, edge seen at k+2.
- PERIOD_OUT, PERIOD_VALID, ALIVE and ERR_FAST update at posedge k+2.
- PERIOD_VALID is high for exactly one cycle per measured interval.
- ERR_TIMEOUT and ALIVE fall are registered at the posedge where cnt == TIMEOUT_CYC with no edge.
- All outputs are registered; there are no combinational input-to-output paths.
- Throughput: one measurement per toggle; the minimum toggle spacing is 2 cycles.

## Test plan
Parameters for all tests: CLOCK_FREQ_MHZ=1, INTERVAL_MSEC=1, TOLERANCE_PCT=10, giving EXPECT=1000, MIN_CYC=900, TIMEOUT_CYC=1100, W=11.
- Reset: hold RESET 5 cycles with HB_IN=1 → all outputs 0, and no PERIOD_VALID during the following 10 cycles.
- Nominal: toggle HB_IN every 1000 cycles.
  - First toggle → no PERIOD_VALID.
  - Second toggle → PERIOD_VALID 1 cycle, PERIOD_OUT=1000, ALIVE=1, both errors 0.
- Lower bound:
  - Interval 899 → PERIOD_OUT=899, ERR_FAST=1, ALIVE=0.
  - Next interval 900 → ALIVE=1, ERR_FAST remains 1.
- Timeout:
  - Stop toggling → ERR_TIMEOUT=1 and ALIVE=0 exactly 1100 cycles after the last edge detection; PERIOD_OUT unchanged.
  - Next toggle → no PERIOD_VALID (re-arm).
  - Following interval 1000 → ALIVE=1.
  - Separately, interval exactly 1100 → PERIOD_OUT=1100, ALIVE=1, ERR_TIMEOUT stays 0.
- Clear priority:
  - Assert CLEAR_ERR in the same cycle as an 899-cycle edge → ERR_FAST=1.
  - Assert CLEAR_ERR one cycle later → ERR_FAST=0, ALIVE unchanged.
- Reset mid-measurement: assert RESET 3 cycles at cnt=500 → outputs 0, state WAIT.
  - Next two toggles 1000 apart → single PERIOD_VALID with PERIOD_OUT=1000.
